// File: rtl/lstm_fx_pkg.sv
// Shared Q8.16 fixed-point definitions for the LSTM datapath.
// Optional build macro: SIGMF_BP_ROUND_EN selects round-to-nearest
// (ties toward +inf) in fx_shift; otherwise fx_shift floors.
package lstm_fx_pkg;

  localparam int WIDTH = 24;
  localparam int FRAC  = 16;

  localparam logic [WIDTH-1:0] FX_ONE  = 24'h010000;
  localparam logic [WIDTH-1:0] FX_HALF = 24'h008000;

  typedef logic signed [WIDTH-1:0] fx_t;

  // Drop FRAC fractional bits from a double-width product and keep the low
  // WIDTH bits; callers guarantee the result fits, so no saturation.
  function automatic fx_t fx_shift(input logic signed [2*WIDTH-1:0] v);
    logic signed [2*WIDTH-1:0] bias;
    logic signed [2*WIDTH-1:0] shifted;
`ifdef SIGMF_BP_ROUND_EN
    bias = (2*WIDTH)'(FX_HALF);
`else
    bias = '0;
`endif
    shifted = (v + bias) >>> FRAC;
    return fx_t'(shifted);
  endfunction

endpackage

// File: rtl/sigmf_bp_lifo_mem.sv
// LIFO storage for sigmf_bp: DEPTH x WIDTH array, one synchronous write
// port and one combinational read-at-index port. Contents are not reset.
module lifo_mem #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the stashed activation on an accepted push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sigmf_bp.sv
// sigmf_bp: backward pass of the piecewise sigmoid. Forward activations y
// are stashed in a LIFO; during BPTT each error g pops the most recent y
// and yields d = g * y * (1 - y) through a two-stage pipeline.
// Optional build macro: SIGMF_BP_ROUND_EN (round-to-nearest shifts).
module sigmf_bp #(
  parameter int WIDTH = lstm_fx_pkg::WIDTH,
  parameter int FRAC  = lstm_fx_pkg::FRAC,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     fwd_valid,
  input  logic [WIDTH-1:0]         fwd_y,
  output logic                     fwd_ready,
  input  logic                     bwd_valid,
  input  logic [WIDTH-1:0]         bwd_g,
  output logic                     bwd_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_d,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);
  import lstm_fx_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(FX_ONE);

  logic             full, empty;
  logic             s1_valid, s1_free, s2_free;
  logic [WIDTH-1:0] s1_g, s1_p;
  logic             push, pop;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [WIDTH-1:0] rd_y, yc, om, p_next, d_next;
  logic [PW-1:0]    y_prod;
  logic signed [PW-1:0] g_ext, p_ext, d_prod;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign s2_free = !out_valid || out_ready;
  assign s1_free = !s1_valid || s2_free;

  // Pops win over pushes, so a push is only offered when no error is waiting.
  assign fwd_ready = !full && !bwd_valid;
  assign bwd_ready = !empty && s1_free;

  assign push = fwd_valid && fwd_ready && !clr;
  assign pop  = bwd_valid && bwd_ready && !clr;

  // The write slot is the current top; the read slot is one below it, which
  // wraps correctly to DEPTH-1 when the LIFO is full.
  assign wr_addr = count[AW-1:0];
  assign rd_addr = wr_addr - AW'(1);

  lifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_addr),
    .wdata (fwd_y),
    .raddr (rd_addr),
    .rdata (rd_y)
  );

  // Stage-1 math: clamp y to 1.0, then p = y * (1 - y) in Q8.16 (0..0.25).
  always_comb begin
    yc     = (rd_y > ONE) ? ONE : rd_y;
    om     = ONE - yc;
    y_prod = PW'(yc) * PW'(om);
    p_next = fx_shift($signed(y_prod));
  end

  // Stage-2 math: signed g times non-negative p; |d| <= |g|/4 so it fits.
  always_comb begin
    g_ext  = {{WIDTH{s1_g[WIDTH-1]}}, s1_g};
    p_ext  = {{WIDTH{1'b0}}, s1_p};
    d_prod = g_ext * p_ext;
    d_next = fx_shift(d_prod);
  end

  // Occupancy and sticky overflow flag; a push attempt while full latches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (clr) begin
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push)      count <= count + CW'(1);
      else if (pop)  count <= count - CW'(1);
      if (fwd_valid && full) overflow_err <= 1'b1;
    end
  end

  // Stage-1 register: capture g and p on every accepted pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (s1_free) begin
      s1_valid <= pop;
      if (pop) begin
        s1_g <= bwd_g;
        s1_p <= p_next;
      end
    end
  end

  // Output register: advances only when downstream can take a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_d     <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_d     <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) out_d <= d_next;
    end
  end

endmodule

// File: tb/tb_sigmf_bp.sv
// Self-checking bench for sigmf_bp: table of single push/pop vectors plus
// directed sequences for LIFO order, full/overflow, backpressure and reset.
module tb_sigmf_bp;

  localparam int WIDTH = 24;
  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic             clk, rst_n, clr;
  logic             fwd_valid, fwd_ready;
  logic [WIDTH-1:0] fwd_y;
  logic             bwd_valid, bwd_ready;
  logic [WIDTH-1:0] bwd_g;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_d;
  logic [CW-1:0]    count;
  logic             overflow_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] got[$];
  int               accepts = 0;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] d;
  } vec_t;

  vec_t tbl[12];

  sigmf_bp #(.WIDTH(WIDTH), .FRAC(16), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .fwd_valid    (fwd_valid),
    .fwd_y        (fwd_y),
    .fwd_ready    (fwd_ready),
    .bwd_valid    (bwd_valid),
    .bwd_g        (bwd_g),
    .bwd_ready    (bwd_ready),
    .out_valid    (out_valid),
    .out_d        (out_d),
    .out_ready    (out_ready),
    .count        (count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record handshakes mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got.push_back(out_d);
      if (bwd_valid && bwd_ready && !clr) accepts++;
    end
  end

  function automatic logic [WIDTH-1:0] p_of(input logic [WIDTH-1:0] y);
    longint unsigned yy;
    yy = (y > 24'h010000) ? 64'h10000 : 64'(y);
    return WIDTH'((yy * (64'h10000 - yy)) >> 16);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [WIDTH-1:0] y,
                               input logic bv, input logic [WIDTH-1:0] g);
    fwd_valid = fv;
    fwd_y     = y;
    bwd_valid = bv;
    bwd_g     = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushOne(input logic [WIDTH-1:0] y);
    applyStimulus(1'b1, y, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic pulseClr();
    applyStimulus(1'b0, '0, 1'b0, '0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ys[6];
    logic [WIDTH-1:0] held;
    int base, acc_base;

    tbl[0]  = '{24'h008000, 24'h010000, 24'h004000};
    tbl[1]  = '{24'h002000, 24'hFF0000, 24'hFFE400};
    tbl[2]  = '{24'h00C000, 24'hFF0000, 24'hFFD000};
    tbl[3]  = '{24'h004000, 24'hFF0000, 24'hFFD000};
    tbl[4]  = '{24'h000000, 24'h010000, 24'h000000};
    tbl[5]  = '{24'h010000, 24'h010000, 24'h000000};
    tbl[6]  = '{24'h012000, 24'h010000, 24'h000000};
    tbl[7]  = '{24'h008000, 24'h020000, 24'h008000};
    tbl[8]  = '{24'h004000, 24'h008000, 24'h001800};
    tbl[9]  = '{24'h008000, 24'hFF8000, 24'hFFE000};
`ifdef SIGMF_BP_ROUND_EN
    tbl[10] = '{24'h008000, 24'hFFFFFF, 24'h000000};
    tbl[11] = '{24'h000003, 24'h010000, 24'h000003};
`else
    tbl[10] = '{24'h008000, 24'hFFFFFF, 24'hFFFFFF};
    tbl[11] = '{24'h000003, 24'h010000, 24'h000002};
`endif

    rst_n = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    #12;
    checkOutput("reset count", 32'(count), 0);
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset out_d", 32'(out_d), 0);
    checkOutput("reset overflow_err", 32'(overflow_err), 0);
    checkOutput("reset fwd_ready", 32'(fwd_ready), 1);
    #10 rst_n = 1'b1;
    tick();

    // Single push/pop per vector; d appears on the second edge counting the accept edge.
    for (int i = 0; i < 12; i++) begin
      pushOne(tbl[i].y);
      applyStimulus(1'b0, '0, 1'b1, tbl[i].g);
      #1;
      checkOutput($sformatf("vec%0d bwd_ready", i), 32'(bwd_ready), 1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput($sformatf("vec%0d early out_valid", i), 32'(out_valid), 0);
      tick();
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
      checkOutput($sformatf("vec%0d out_d", i), 32'(out_d), 32'(tbl[i].d));
      tick();
    end

    // Three zero-gradient entries popped back to back; count walks 3..0.
    pushOne(24'h000000);
    pushOne(24'h010000);
    pushOne(24'h012000);
    checkOutput("seq1 count", 32'(count), 3);
    base = got.size();
    applyStimulus(1'b0, '0, 1'b1, 24'h010000);
    #1;
    checkOutput("seq1 fwd_ready blocked by pop", 32'(fwd_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("seq1 count step%0d", k), 32'(count), 32'(2 - k));
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick(); tick(); tick();
    checkOutput("seq1 outputs", 32'(got.size() - base), 3);
    for (int k = base; k < got.size(); k++)
      checkOutput($sformatf("seq1 d%0d", k - base), 32'(got[k]), 0);

    // Negative gradient: LIFO order and sign.
    pushOne(24'h004000);
    pushOne(24'h00C000);
    pushOne(24'h002000);
    base = got.size();
    applyStimulus(1'b0, '0, 1'b1, 24'hFF0000);
    tick(); tick(); tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    for (int w = 0; w < 10 && got.size() - base < 3; w++) tick();
    checkOutput("seq2 outputs", 32'(got.size() - base), 3);
    if (got.size() - base >= 3) begin
      checkOutput("seq2 d0", 32'(got[base]),     32'h00FFE400);
      checkOutput("seq2 d1", 32'(got[base + 1]), 32'h00FFD000);
      checkOutput("seq2 d2", 32'(got[base + 2]), 32'h00FFD000);
    end

    // Fill to DEPTH, overflow attempt, then check the top entry survived.
    pulseClr();
    for (int i = 0; i < DEPTH; i++) pushOne(WIDTH'(i * 24'h000400));
    checkOutput("full count", 32'(count), DEPTH);
    checkOutput("full fwd_ready", 32'(fwd_ready), 0);
    checkOutput("full overflow before", 32'(overflow_err), 0);
    pushOne(24'h00ABCD);
    checkOutput("overflow_err set", 32'(overflow_err), 1);
    checkOutput("overflow count", 32'(count), DEPTH);
    base = got.size();
    applyStimulus(1'b0, '0, 1'b1, 24'h010000);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick(); tick();
    checkOutput("full top outputs", 32'(got.size() - base), 1);
    if (got.size() > base) checkOutput("full top d", 32'(got[base]), 32'h3F0);
    checkOutput("overflow sticky", 32'(overflow_err), 1);
    pulseClr();
    checkOutput("clr count", 32'(count), 0);
    checkOutput("clr overflow_err", 32'(overflow_err), 0);
    checkOutput("clr out_valid", 32'(out_valid), 0);
    acc_base = accepts;
    applyStimulus(1'b0, '0, 1'b1, 24'h010000);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("empty bwd_ready%0d", k), 32'(bwd_ready), 0);
      tick();
      checkOutput($sformatf("empty out_valid%0d", k), 32'(out_valid), 0);
    end
    checkOutput("empty accepts", 32'(accepts - acc_base), 0);
    applyStimulus(1'b0, '0, 1'b0, '0);

    // Backpressure: 5 stalled cycles, then drain in order.
    ys = '{24'h008000, 24'h004000, 24'h00C000, 24'h002000, 24'h00E000, 24'h001000};
    for (int i = 0; i < 6; i++) pushOne(ys[i]);
    base = got.size();
    acc_base = accepts;
    out_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 24'h010000);
    tick(); tick();
    held = out_d;
    checkOutput("bp out_d first", 32'(held), 32'(p_of(ys[5])));
    tick(); tick(); tick();
    checkOutput("bp accepts", 32'(accepts - acc_base), 2);
    checkOutput("bp bwd_ready", 32'(bwd_ready), 0);
    checkOutput("bp out_valid", 32'(out_valid), 1);
    checkOutput("bp out_d held", 32'(out_d), 32'(held));
    checkOutput("bp no consume", 32'(got.size() - base), 0);
    out_ready = 1'b1;
    for (int w = 0; w < 30 && got.size() - base < 6; w++) tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick(); tick();
    checkOutput("bp outputs", 32'(got.size() - base), 6);
    if (got.size() - base >= 6)
      for (int k = 0; k < 6; k++)
        checkOutput($sformatf("bp d%0d", k), 32'(got[base + k]), 32'(p_of(ys[5 - k])));

    // Asynchronous reset while a result is valid.
    pushOne(24'h008000);
    pushOne(24'h008000);
    pushOne(24'h008000);
    applyStimulus(1'b0, '0, 1'b1, 24'h010000);
    for (int w = 0; w < 10 && !out_valid; w++) tick();
    checkOutput("rst pre out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst async out_valid", 32'(out_valid), 0);
    checkOutput("rst async count", 32'(count), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("rst stall bwd_ready%0d", k), 32'(bwd_ready), 0);
      checkOutput($sformatf("rst stall out_valid%0d", k), 32'(out_valid), 0);
    end
    applyStimulus(1'b0, '0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sigmf_bp.md
Name: sigmf_bp

Overview:
- Backward-pass companion to the partially-linear sigmoid activation used in the LSTM datapath.
- During the forward pass it stashes sigmoid outputs y in an internal LIFO.
- During backpropagation-through-time it pops them in reverse order and computes the local gradient d = g * y * (1 - y) for each incoming error g.
- Sits between the LSTM gate activation stage and the gate-delta accumulation logic.

Parameters:
- WIDTH, 24: data width; fixed point Q8.16, two's complement, 0x010000 = 1.0.
- FRAC, 16: fractional bits.
- DEPTH, 64: LIFO entries, i.e. maximum stashed time steps; power of two.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: empties LIFO, drops pipeline contents
- fwd_valid  in  1  forward activation y available
- fwd_y  in  WIDTH  sigmoid output y, expected range 0x000000..0x010000
- fwd_ready  out  1  push accepted when fwd_valid && fwd_ready
- bwd_valid  in  1  backward error g available
- bwd_g  in  WIDTH  signed error g
- bwd_ready  out  1  g accepted (and y popped) when bwd_valid && bwd_ready
- out_valid  out  1  d valid
- out_d  out  WIDTH  signed local gradient d
- out_ready  in  1  downstream accepts d
- count  out  $clog2(DEPTH)+1  LIFO occupancy
- overflow_err  out  1  sticky; set on push attempt while full (fwd_valid && !fwd_ready because full); cleared by clr/reset

Behaviour:
- Reset (async, rst_n=0) and clr (sync): count=0, out_valid=0, out_d=0, all pipeline valids=0, overflow_err=0. Reset mid-operation discards all stashed y and in-flight results. LIFO RAM contents need no reset.
- Push: fwd_ready = (count != DEPTH) && !bwd_valid. Pop has priority: a push is never accepted in a cycle where bwd_valid=1.
  - Accepted push writes mem[count] and increments count.
- Pop/accept: bwd_ready = (count != 0) && s1_free.
  - s1_free = !s1_valid || s2_free; s2_free = !out_valid || out_ready.
  - An accepted pop reads mem[count-1] and decrements count.
  - bwd_valid while empty is simply stalled; no error.
- Stage 1, registered on accept:
  - yc = min(y, 0x010000), so y is clamped to 1.0.
  - om = 0x010000 - yc.
  - p = (yc * om) >> FRAC, unsigned, truncating; p range 0..0x004000.
  - g is registered alongside p; s1_valid set.
- Stage 2, registered when s2_free:
  - Full product g(signed) * p(signed, zero-extended), 2*WIDTH bits.
  - d = product >>> FRAC, arithmetic shift (floor).
  - No saturation needed, since |d| <= |g|/4.
  - out_valid follows s1_valid.
- Latency: out_valid rises 2 cycles after the accept edge when unstalled. Throughput is 1 per cycle.
- Backpressure: with out_ready=0, out_d/out_valid hold stable, stage 1 fills, then bwd_ready drops. No data is lost or duplicated.
- Ordering: outputs appear in strict LIFO order of stashed y.
- clr has priority over push/pop in the same cycle.

Optional Feature:
- Macro: SIGMF_BP_ROUND_EN.
- Defined: both the stage-1 and stage-2 shifts round to nearest by adding 1<<(FRAC-1) before the shift (ties toward +inf).
- Undefined: both shifts truncate (floor) as above.
- Latency is unchanged either way.

Decomposition:
- Shared package (lstm_fx_pkg) holds:
  - WIDTH, FRAC
  - FX_ONE = 0x010000, FX_HALF = 0x008000
  - the Q8.16 fixed-point typedef
  - a rounding/shift helper function
- Sub-module lifo_mem: DEPTH x WIDTH storage with write port and read-at-index port, combinational read, no reset.
- Pointer/count logic stays in sigmf_bp.

Test Plan:
- Push y=0x008000, then bwd g=0x010000 -> out_d=0x004000 exactly 2 cycles after accept.
- Push y=0x000000, 0x010000, 0x012000; pop three with g=0x010000 -> d=0x000000 three times, in reverse order; count goes 3->0.
- Push 0x004000, 0x00C000, then 0x002000; pop with g=0xFF0000 (-1.0):
  - d = -(0x002000 * 0x00E000 >> 16) = 0xFFE400 first;
  - then 0xFFD000 for 0x00C000 and for 0x004000.
  - Check LIFO order and sign.
- Fill DEPTH entries -> fwd_ready=0, count=DEPTH. Extra push sets overflow_err=1; clr clears it and count=0. bwd_valid while empty -> bwd_ready=0, no output.
- Backpressure: out_ready=0 for 5 cycles during a pop stream -> out_d held, bwd_ready drops after 2 accepts, no loss. Release -> remaining results in order.
- Assert rst_n low mid-stream with out_valid=1 -> out_valid=0, count=0 asynchronously. The next bwd_valid stalls.
